uart_recv: RTL and testbench

UART receiver for 8N1 serial frames (1 start, 8 data LSB first, 1 stop, no parity), idle-high line. It is the receive counterpart of the board's UART transmitter: it samples `uart_din` at mid-bit and presents each complete byte as a one-cycle valid pulse with data. Downstream logic (e.g. the segment display path) consumes the byte. The block also flags framing errors and reports when a frame is in progress.

---
 rtl/uart_recv.sv | 126 ++++++++++++
 tb/tb_uart_recv.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/uart_recv.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling, one-cycle byte/framing-error pulses.
// States: IDLE wait for falling edge | START confirm start at half bit | DATA shift 8 bits | STOP check stop bit
module uart_recv #(
    parameter int BIT_CYCLES = 10417
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_din,
    output logic       din_vld,
    output logic [7:0] din_data,
    output logic       frame_err,
    output logic       busy
);
    localparam int HALF = BIT_CYCLES / 2;
    localparam int CW   = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(BIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state_q, state_d;
    logic          s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    sh_q, sh_d;
    logic [7:0]    din_data_q, din_data_d;
    logic          din_vld_q, din_vld_d;
    logic          frame_err_q, frame_err_d;
    logic          fall;

    assign fall = s3_q & ~s2_q;

    always_comb begin
        s1_d        = uart_din;
        s2_d        = s1_q;
        s3_d        = s2_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        sh_d        = sh_q;
        din_data_d  = din_data_q;
        din_vld_d   = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (fall) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    // A start bit that has gone high again by mid-bit is treated as line noise.
                    if (!s2_q) begin
                        state_d = DATA;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == BIT_M1) begin
                    sh_d[idx_q] = s2_q;
                    cnt_d       = '0;
                    if (idx_q == 3'd7) state_d = STOP;
                    else idx_d = idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (s2_q) begin
                        din_data_d = sh_q;
                        din_vld_d  = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            s1_q        <= 1'b1;
            s2_q        <= 1'b1;
            s3_q        <= 1'b1;
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            sh_q        <= 8'h00;
            din_data_q  <= 8'h00;
            din_vld_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            sh_q        <= sh_d;
            din_data_q  <= din_data_d;
            din_vld_q   <= din_vld_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign din_vld   = din_vld_q;
    assign din_data  = din_data_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_uart_recv.sv
// Bench for uart_recv: frame table driven bit by bit, expected pulses queued and matched by a monitor.
module tb_uart_recv;
    localparam int BC   = 16;
    localparam int HALF = BC / 2;
    localparam int LAT  = 2 + HALF + 9 * BC;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_din = 1'b1;
    logic       din_vld, frame_err, busy;
    logic [7:0] din_data;

    uart_recv #(.BIT_CYCLES(BC)) dut (
        .clk      (clk),
        .rst      (rst),
        .uart_din (uart_din),
        .din_vld  (din_vld),
        .din_data (din_data),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] data;
        bit         err;
        int         at;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        bit         stop_bit;
        bit         abort;
        int         gap;
        int         hold_low;
        logic [7:0] exp_data;
    } vec_t;

    exp_t sbq[$];
    exp_t mon_e;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Every pulse must match the head of the queue; a head whose cycle has passed is a missed pulse.
    always @(negedge clk) begin
        if (din_vld === 1'b1 || frame_err === 1'b1) begin
            check("vld_err_exclusive", 32'(din_vld & frame_err), 32'd0);
            if (sbq.size() == 0) begin
                check("unexpected_pulse", 32'({din_vld, frame_err}), 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                check("pulse_cycle", 32'(cyc), 32'(mon_e.at));
                check("pulse_is_err", 32'(frame_err), 32'(mon_e.err));
                check("pulse_data", 32'(din_data), 32'(mon_e.data));
            end
        end else if (sbq.size() != 0 && cyc > sbq[0].at) begin
            check("missing_pulse_cycle", 32'(cyc), 32'(sbq[0].at));
            void'(sbq.pop_front());
        end
    end

    task automatic send_frame(input logic [7:0] b, input bit stop_bit,
                              input logic [7:0] exp_data, input bit abort);
        int k;
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        k = cyc + 1;
        if (!abort) sbq.push_back('{exp_data, !stop_bit, k + LAT});
        for (int j = 0; j < 10; j++) begin
            uart_din = bits[j];
            for (int c = 0; c < BC; c++) begin
                if (abort && j == 4 && c == 5) begin
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    uart_din = 1'b1;
                    check("abort_busy", 32'(busy), 32'd0);
                    check("abort_data", 32'(din_data), 32'h00);
                    return;
                end
                @(negedge clk);
                if (j == 0 && c == 1) check("busy_before_start", 32'(busy), 32'd0);
                if (j == 0 && c == 2) check("busy_at_k2", 32'(busy), 32'd1);
            end
        end
        check("busy_after_frame", 32'(busy), 32'd0);
    endtask

    initial begin
        int busy_cnt;
        vecs[0] = '{8'h55, 1'b1, 1'b0, 20,  0,  8'h55};
        vecs[1] = '{8'hA3, 1'b1, 1'b0, 30,  0,  8'hA3};
        vecs[2] = '{8'h0F, 1'b1, 1'b0, 0,   0,  8'h0F};
        vecs[3] = '{8'h55, 1'b1, 1'b0, 20,  0,  8'h55};
        vecs[4] = '{8'hFF, 1'b0, 1'b0, 20,  40, 8'h55};
        vecs[5] = '{8'h12, 1'b1, 1'b0, 20,  0,  8'h12};
        vecs[6] = '{8'h3C, 1'b1, 1'b1, 20,  0,  8'h00};
        vecs[7] = '{8'hC6, 1'b1, 1'b0, 200, 0,  8'hC6};

        rst = 1'b1;
        uart_din = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_vld", 32'(din_vld), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data", 32'(din_data), 32'h00);

        busy_cnt = 0;
        repeat (200) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        check("idle_busy_cycles", 32'(busy_cnt), 32'd0);

        for (int i = 0; i < 8; i++) begin
            uart_din = 1'b1;
            repeat (vecs[i].gap) @(negedge clk);
            send_frame(vecs[i].data, vecs[i].stop_bit, vecs[i].exp_data, vecs[i].abort);
            if (vecs[i].hold_low > 0) begin
                uart_din = 1'b0;
                repeat (vecs[i].hold_low) @(negedge clk);
                check("low_hold_no_restart", 32'(busy), 32'd0);
                check("data_kept_after_err", 32'(din_data), 32'(vecs[i].exp_data));
            end
        end

        // Short low glitch: START runs for half a bit, then gives up.
        uart_din = 1'b1;
        repeat (30) @(negedge clk);
        busy_cnt = 0;
        uart_din = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (c == 4) uart_din = 1'b1;
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        check("glitch_busy_cycles", 32'(busy_cnt), 32'(HALF));
        check("glitch_busy_end", 32'(busy), 32'd0);
        check("glitch_data_kept", 32'(din_data), 32'hC6);

        repeat (300) @(negedge clk);
        check("sb_leftover", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
